fc_argmax_1: RTL and testbench

//  Classifier stage directly downstream of fc_layer_1. Snoops the FC output-neuron write stream
//  (data, address, write-enable into the outneuron RAM), tracks the running signed maximum over

---
 rtl/fc_argmax_1_pkg.sv | 17 +
 rtl/fc_argmax_cmp_1.sv | 50 +++++
 rtl/fc_argmax_1.sv | 166 ++++++++++++++++
 tb/tb_fc_argmax_1.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_argmax_1_pkg.sv
// Shared parameters and FSM state type for the FC argmax classifier stage.
// These are the defaults that the fc_argmax_1 parameters start from.
package fc_argmax_1_pkg;

    localparam int FC_DATA_WIDTH_DEFAULT       = 16;
    localparam int FC_OUTNEURON_DEFAULT        = 10;
    localparam int FC_ADDR_WIDTH_DEFAULT       = 9;
    localparam int FC_COUNT_WIDTH_DEFAULT      = 4;

    // Frame-level states: wait for arm, gather scores, present result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } fc_argmax_state_t;

endpackage

// File: rtl/fc_argmax_cmp_1.sv
// Combinational signed compare/select of an incoming (score, index) against the
// running winner. With FC_ARGMAX_TOP2_EN defined it also maintains the runner-up.
// Ties always keep the earlier-arriving score.
module fc_argmax_cmp_1 #(
    parameter int DATA_WIDTH_FC                = 16,
    parameter int FC_COUNT_OUT_NEURON_BITWIDTH = 4
) (
    input  logic [DATA_WIDTH_FC-1:0]                score,
    input  logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] index,
    input  logic                                    take_first,
    input  logic [DATA_WIDTH_FC-1:0]                cur_max,
    input  logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] cur_idx,
`ifdef FC_ARGMAX_TOP2_EN
    input  logic                                    take_second,
    input  logic [DATA_WIDTH_FC-1:0]                cur_second,
    input  logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] cur_second_idx,
    output logic [DATA_WIDTH_FC-1:0]                new_second,
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] new_second_idx,
`endif
    output logic [DATA_WIDTH_FC-1:0]                new_max,
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] new_idx
);

    logic wins;

    // Strict signed compare; the first accepted score of a frame always wins so
    // an all-most-negative frame reports that score's own index.
    always_comb begin
        wins    = take_first || ($signed(score) > $signed(cur_max));
        new_max = wins ? score : cur_max;
        new_idx = wins ? index : cur_idx;
    end

`ifdef FC_ARGMAX_TOP2_EN
    // Runner-up: a new max demotes the old one, else strict > replaces; the
    // second accepted score seeds the slot unconditionally.
    always_comb begin
        new_second     = cur_second;
        new_second_idx = cur_second_idx;
        if (wins) begin
            new_second     = cur_max;
            new_second_idx = cur_idx;
        end else if (take_second || ($signed(score) > $signed(cur_second))) begin
            new_second     = score;
            new_second_idx = index;
        end
    end
`endif

endmodule

// File: rtl/fc_argmax_1.sv
// FC argmax classifier: snoops the FC output-neuron write stream, keeps the
// running signed maximum over OUTNEURON scores per frame and reports the winning
// class index and score once per frame.
// Optional feature macro: FC_ARGMAX_TOP2_EN (adds second_out and margin outputs).
module fc_argmax_1
    import fc_argmax_1_pkg::*;
#(
    parameter int DATA_WIDTH_FC                = FC_DATA_WIDTH_DEFAULT,
    parameter int OUTNEURON                    = FC_OUTNEURON_DEFAULT,
    parameter int FC_OUTNEURON_ADDR_WIDTH      = FC_ADDR_WIDTH_DEFAULT,
    parameter int FC_COUNT_OUT_NEURON_BITWIDTH = FC_COUNT_WIDTH_DEFAULT
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic                                    in_valid,
    input  logic [FC_OUTNEURON_ADDR_WIDTH-1:0]      in_addr,
    input  logic [DATA_WIDTH_FC-1:0]                in_data,
    output logic                                    busy,
    output logic                                    class_valid,
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] class_out,
    output logic [DATA_WIDTH_FC-1:0]                max_score,
`ifdef FC_ARGMAX_TOP2_EN
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] second_out,
    output logic [DATA_WIDTH_FC:0]                  margin,
`endif
    output logic                                    err_addr
);

    localparam int CW = FC_COUNT_OUT_NEURON_BITWIDTH;
    localparam logic [DATA_WIDTH_FC-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH_FC-1){1'b0}}};

    fc_argmax_state_t state, state_next;

    logic [CW-1:0]            count;
    logic [DATA_WIDTH_FC-1:0] run_max;
    logic [CW-1:0]            run_idx;
    logic [DATA_WIDTH_FC-1:0] cmp_max;
    logic [CW-1:0]            cmp_idx;
    logic                     in_range;
    logic                     accept;
    logic                     last;
    logic                     arm;

`ifdef FC_ARGMAX_TOP2_EN
    logic [DATA_WIDTH_FC-1:0] run_second;
    logic [CW-1:0]            run_second_idx;
    logic [DATA_WIDTH_FC-1:0] cmp_second;
    logic [CW-1:0]            cmp_second_idx;
`endif

    // Qualify the snooped write strobe for the current frame.
    always_comb begin
        in_range = (in_addr < FC_OUTNEURON_ADDR_WIDTH'(OUTNEURON));
        accept   = (state == COLLECT) && in_valid && in_range;
        last     = accept && (count == CW'(OUTNEURON - 1));
        arm      = (state != COLLECT) && enable;
    end

    fc_argmax_cmp_1 #(
        .DATA_WIDTH_FC                (DATA_WIDTH_FC),
        .FC_COUNT_OUT_NEURON_BITWIDTH (CW)
    ) u_cmp (
        .score          (in_data),
        .index          (in_addr[CW-1:0]),
        .take_first     (count == '0),
        .cur_max        (run_max),
        .cur_idx        (run_idx),
`ifdef FC_ARGMAX_TOP2_EN
        .take_second    (count == CW'(1)),
        .cur_second     (run_second),
        .cur_second_idx (run_second_idx),
        .new_second     (cmp_second),
        .new_second_idx (cmp_second_idx),
`endif
        .new_max        (cmp_max),
        .new_idx        (cmp_idx)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: arm from IDLE/REPORT, leave COLLECT on the last score.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = enable ? COLLECT : IDLE;
            COLLECT: state_next = last ? REPORT : COLLECT;
            REPORT:  state_next = enable ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy        = (state == COLLECT);
        class_valid = (state == REPORT);
    end

    // Running winner, accepted-score counter and sticky address error.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            run_max  <= MOST_NEG;
            run_idx  <= '0;
            err_addr <= 1'b0;
        end else if (arm) begin
            count    <= '0;
            run_max  <= MOST_NEG;
            run_idx  <= '0;
            err_addr <= 1'b0;
        end else if (state == COLLECT && in_valid) begin
            if (in_range) begin
                count   <= count + CW'(1);
                run_max <= cmp_max;
                run_idx <= cmp_idx;
            end else begin
                err_addr <= 1'b1;
            end
        end
    end

    // Result registers: load the final winner (including the last score) so it
    // is visible in the REPORT cycle, then hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            class_out <= '0;
            max_score <= '0;
        end else if (last) begin
            class_out <= cmp_idx;
            max_score <= cmp_max;
        end
    end

`ifdef FC_ARGMAX_TOP2_EN
    // Runner-up tracking, re-initialised alongside the running max.
    always_ff @(posedge clock) begin
        if (reset || arm) begin
            run_second     <= MOST_NEG;
            run_second_idx <= '0;
        end else if (accept) begin
            run_second     <= cmp_second;
            run_second_idx <= cmp_second_idx;
        end
    end

    // Top-2 result registers, updated together with class_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            second_out <= '0;
            margin     <= '0;
        end else if (last) begin
            second_out <= cmp_second_idx;
            margin     <= {cmp_max[DATA_WIDTH_FC-1], cmp_max}
                        - {cmp_second[DATA_WIDTH_FC-1], cmp_second};
        end
    end
`endif

endmodule

// File: tb/tb_fc_argmax_1.sv
// Self-checking bench for fc_argmax_1: a frame-level reference model (queue of
// accepted scores, argmax by a plain loop) checked every cycle, plus directed
// scenarios with literal expectations. Build with FC_ARGMAX_TOP2_EN to also
// check second_out/margin.
module tb_fc_argmax_1;

    localparam int DW = 16;
    localparam int NO = 10;
    localparam int AW = 9;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          class_valid;
    logic [CW-1:0] class_out;
    logic [DW-1:0] max_score;
    logic          err_addr;
`ifdef FC_ARGMAX_TOP2_EN
    logic [CW-1:0] second_out;
    logic [DW:0]   margin;
`endif

    fc_argmax_1 #(
        .DATA_WIDTH_FC                (DW),
        .OUTNEURON                    (NO),
        .FC_OUTNEURON_ADDR_WIDTH      (AW),
        .FC_COUNT_OUT_NEURON_BITWIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .busy        (busy),
        .class_valid (class_valid),
        .class_out   (class_out),
        .max_score   (max_score),
`ifdef FC_ARGMAX_TOP2_EN
        .second_out  (second_out),
        .margin      (margin),
`endif
        .err_addr    (err_addr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 waiting for arm, 1 gathering scores, 2 result cycle
    int            m_mode = 0;
    int            q_data[$];
    int            q_addr[$];
    logic          started = 1'b0;
    logic [CW-1:0] e_class = '0;
    logic [DW-1:0] e_max = '0;
    logic          e_err = 1'b0;
    logic [CW-1:0] e_sec = '0;
    logic [DW:0]   e_marg = '0;

    always @(posedge clock) begin
        int b;
        int s;
        int tmp;
        if (reset) begin
            m_mode = 0;
            q_data.delete();
            q_addr.delete();
            e_class = '0;
            e_max   = '0;
            e_err   = 1'b0;
            e_sec   = '0;
            e_marg  = '0;
        end else if (m_mode == 1) begin
            if (in_valid) begin
                if (in_addr < NO) begin
                    q_data.push_back($signed(in_data));
                    q_addr.push_back(int'(in_addr));
                    if (q_data.size() == NO) begin
                        b = 0;
                        for (int i = 1; i < NO; i++)
                            if (q_data[i] > q_data[b]) b = i;
                        s = -1;
                        for (int i = 0; i < NO; i++)
                            if (i != b && (s < 0 || q_data[i] > q_data[s])) s = i;
                        tmp     = q_addr[b];
                        e_class = tmp[CW-1:0];
                        tmp     = q_data[b];
                        e_max   = tmp[DW-1:0];
                        tmp     = q_addr[s];
                        e_sec   = tmp[CW-1:0];
                        tmp     = q_data[b] - q_data[s];
                        e_marg  = tmp[DW:0];
                        m_mode  = 2;
                    end
                end else begin
                    e_err = 1'b1;
                end
            end
        end else begin
            if (enable) begin
                m_mode = 1;
                q_data.delete();
                q_addr.delete();
                e_err = 1'b0;
            end else begin
                m_mode = 0;
            end
        end
        started = 1'b1;
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            chk("busy",        {31'b0, busy},        {31'b0, m_mode == 1});
            chk("class_valid", {31'b0, class_valid}, {31'b0, m_mode == 2});
            chk("class_out",   {28'b0, class_out},   {28'b0, e_class});
            chk("max_score",   {16'b0, max_score},   {16'b0, e_max});
            chk("err_addr",    {31'b0, err_addr},    {31'b0, e_err});
`ifdef FC_ARGMAX_TOP2_EN
            chk("second_out",  {28'b0, second_out},  {28'b0, e_sec});
            chk("margin",      {15'b0, margin},      {15'b0, e_marg});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input int a, input int d);
        in_valid = v;
        in_addr  = a[AW-1:0];
        in_data  = d[DW-1:0];
        @(negedge clock);
    endtask

    task automatic arm_once();
        enable = 1'b1;
        cyc(1'b0, 0, 0);
        enable = 1'b0;
    endtask

    int t1[NO] = '{5, -3, 12, 7, 12, 0, -1, 2, 3, 4};

    initial begin
        int d;
        int a;
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_busy",      {31'b0, busy},        32'd0);
        chk("reset_class_out", {28'b0, class_out},   32'd0);
        chk("reset_max_score", {16'b0, max_score},   32'd0);
        chk("reset_valid",     {31'b0, class_valid}, 32'd0);

        // 1: tie at 12 keeps the earlier address 2
        arm_once();
        for (int i = 0; i < NO; i++) cyc(1'b1, i, t1[i]);
        chk("t1_valid", {31'b0, class_valid}, 32'd1);
        chk("t1_class", {28'b0, class_out},   32'd2);
        chk("t1_max",   {16'b0, max_score},   32'd12);
`ifdef FC_ARGMAX_TOP2_EN
        chk("t1_second", {28'b0, second_out}, 32'd4);
        chk("t1_margin", {15'b0, margin},     32'd0);
`endif
        cyc(1'b0, 0, 0);
        chk("t1_pulse_end", {31'b0, class_valid}, 32'd0);
        chk("t1_hold",      {28'b0, class_out},   32'd2);

        // 2: all scores most-negative
        arm_once();
        for (int i = 0; i < NO; i++) cyc(1'b1, i, 32'h8000);
        chk("t2_class", {28'b0, class_out}, 32'd0);
        chk("t2_max",   {16'b0, max_score}, 32'h8000);
        chk("t2_err",   {31'b0, err_addr},  32'd0);
        cyc(1'b0, 0, 0);

        // 3: out-of-range address mid-frame
        arm_once();
        for (int i = 0; i < 5; i++) cyc(1'b1, i, i);
        cyc(1'b1, 12, 999);
        for (int i = 5; i < NO; i++) cyc(1'b1, i, i);
        chk("t3_valid", {31'b0, class_valid}, 32'd1);
        chk("t3_err",   {31'b0, err_addr},    32'd1);
        chk("t3_class", {28'b0, class_out},   32'd9);
        cyc(1'b0, 0, 0);
        chk("t3_err_sticky", {31'b0, err_addr}, 32'd1);
        arm_once();
        chk("t3_err_cleared", {31'b0, err_addr}, 32'd0);
        for (int i = 0; i < NO; i++) cyc(1'b1, i, 100 - i);
        chk("t3_class2", {28'b0, class_out}, 32'd0);
        cyc(1'b0, 0, 0);

        // 4: reset mid-frame
        arm_once();
        for (int i = 0; i < 6; i++) cyc(1'b1, i, 50 + i);
        reset = 1'b1;
        cyc(1'b0, 0, 0);
        reset = 1'b0;
        chk("t4_busy",  {31'b0, busy},        32'd0);
        chk("t4_valid", {31'b0, class_valid}, 32'd0);
        chk("t4_class", {28'b0, class_out},   32'd0);
        chk("t4_max",   {16'b0, max_score},   32'd0);
        repeat (3) cyc(1'b0, 0, 0);
        chk("t4_no_pulse", {31'b0, class_valid}, 32'd0);
        arm_once();
        for (int i = 0; i < NO; i++) cyc(1'b1, i, 10 * i);
        chk("t4_class_after", {28'b0, class_out}, 32'd9);
        chk("t4_max_after",   {16'b0, max_score}, 32'd90);
        cyc(1'b0, 0, 0);

        // 5: back-to-back frames with enable held high
        enable = 1'b1;
        cyc(1'b0, 0, 0);
        for (int i = 0; i < NO; i++) cyc(1'b1, i, 3 * i);
        chk("t5_a_valid", {31'b0, class_valid}, 32'd1);
        chk("t5_a_class", {28'b0, class_out},   32'd9);
        cyc(1'b1, 0, 30000);
        chk("t5_rearm_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < NO; i++) begin
            if (i == NO - 1) enable = 1'b0;
            cyc(1'b1, i, (i == 1) ? 20 : -5);
        end
        chk("t5_b_valid", {31'b0, class_valid}, 32'd1);
        chk("t5_b_class", {28'b0, class_out},   32'd1);
        chk("t5_b_max",   {16'b0, max_score},   32'd20);
        cyc(1'b0, 0, 0);

        // 6: strobes in IDLE are ignored
        for (int i = 0; i < 5; i++) cyc(1'b1, i, 1000 + i);
        chk("t6_busy",  {31'b0, busy},        32'd0);
        chk("t6_valid", {31'b0, class_valid}, 32'd0);
        chk("t6_class", {28'b0, class_out},   32'd1);
        chk("t6_max",   {16'b0, max_score},   32'd20);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       d = $urandom_range(0, 3);
                1:       d = ($urandom_range(0, 1) == 1) ? 32'h8000 : 32'h7fff;
                default: d = int'($urandom);
            endcase
            a = ($urandom_range(0, 19) == 0) ? $urandom_range(NO, 511) : $urandom_range(0, NO - 1);
            cyc($urandom_range(0, 9) < 7, a, d);
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) cyc(1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
